pipeline_control: RTL
=====================

Name: pipeline_control

Overview:
- Parametrised successor to the single-cycle MIPS control decoder for the 5-stage pipeline.
- Decodes OP/Funct in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards and generates stall/bubble signals.
- Resolves branches, J, JAL and JR into PC-select and flush signals.

Parameters:
- REG_ADDR_WIDTH, 5: register-file address width; JAL link register = 2**REG_ADDR_WIDTH-1.
- ALUOP_WIDTH, 3: ALUOp width (>=3); codes are zero-extended.
- BRANCH_STAGE, 2: stage where branches resolve. 1 = EX, 2 = MEM.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous active-low reset.
- OP  in  6  opcode of the instruction in ID (IF/ID register).
- Funct  in  6  funct field of the ID instruction.
- Rs  in  REG_ADDR_WIDTH  rs field of the ID instruction.
- Rt  in  REG_ADDR_WIDTH  rt field of the ID instruction.
- Rd  in  REG_ADDR_WIDTH  rd field of the ID instruction.
- Zero  in  1  ALU zero flag, belonging to the BRANCH_STAGE instruction.
- hold  in  1  external freeze (memory wait); no stage advances.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  zero the IF/ID register next edge.
- PCSrc  out  2  PC select. 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (JR).
- EX_RegDst  out  1  EX-stage RegDst.
- EX_ALUSrc  out  1  EX-stage ALUSrc.
- EX_ALUOp  out  ALUOP_WIDTH  EX-stage ALUOp.
- MEM_MemRead  out  1  MEM-stage MemRead.
- MEM_MemWrite  out  1  MEM-stage MemWrite.
- WB_RegWrite  out  1  WB-stage RegWrite.
- WB_MemtoReg  out  1  WB-stage write-back select; 1 selects memory data.
- WB_WriteReg  out  REG_ADDR_WIDTH  WB-stage destination register.

Behaviour:
- Reset (reset=0, asynchronous): all stage registers clear.
  - All EX_/MEM_/WB_ outputs read 0.
  - PCSrc=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0.
- Reset mid-operation discards every in-flight bundle; no write or memory strobe may occur after reset asserts.
- ID decode is combinational.
  - Destination register: Rd for R-type, Rt for I-type, all-ones for JAL.
  - ALUOp codes: R=7, ADDI=4, ORI=5, ANDI=6, LUI=1, LW/SW=2, BEQ/BNE=3, J/JAL/unknown=0.
  - Writers are R-type except JR, ADDI, ORI, ANDI, LUI, LW and JAL.
  - JR is OP=0 with Funct=0x08. It writes no register.
  - Unknown opcodes decode to an all-zero bundle (NOP).
- Stage registers advance on the rising clk edge when hold=0. Latency from ID decode to the EX_ outputs is 1 cycle; each further stage adds 1 cycle.
- Load-use hazard condition:
  - The ID/EX instruction has MemRead=1 and a non-zero destination.
  - That destination equals Rs, or equals Rt for an instruction that reads Rt (R-type, SW, BEQ, BNE).
- On a load-use hazard: PCWrite=0, IFIDWrite=0, and a zero bundle is loaded into ID/EX.
- J, JAL and JR in ID:
  - PCSrc=2 (J, JAL) or 3 (JR), combinationally.
  - IFIDFlush=1 for one cycle.
  - The jump bundle itself continues down the pipe; JAL writes the link register.
- Branch taken = (BranchEQ & Zero) | (BranchNE & ~Zero), evaluated for the bundle in BRANCH_STAGE.
- On a taken branch:
  - PCSrc=1 and IFIDFlush=1.
  - Zero bundles are loaded into every younger stage register: ID/EX, plus EX/MEM when BRANCH_STAGE=2.
- Priority when events coincide:
  - Taken branch > load-use stall > jump in ID.
  - A jump or stalled instruction squashed by a taken branch has no effect.
  - PCWrite=1 whenever a branch is taken.
- hold=1 has top priority:
  - All stage registers and outputs freeze and PCWrite=IFIDWrite=0.
  - Flush and PCSrc requests are deferred until hold deasserts.
- Outputs are pure functions of the stage registers, except PCWrite, IFIDWrite, IFIDFlush and PCSrc, which are combinational.

Test Plan:
- Reset pulse low for 2 cycles mid-stream (LW in EX/MEM) -> MEM_MemRead=0 and WB_RegWrite=0 immediately; all stage outputs stay 0 until new instructions arrive.
- ADDI (OP=0x08, Rt=3) enters ID -> next cycle EX_ALUOp=4, EX_ALUSrc=1; 2 cycles later WB_RegWrite=1, WB_WriteReg=3, WB_MemtoReg=0.
- LW writing r5, followed by R-type with Rs=5 -> one cycle with PCWrite=0, IFIDWrite=0 and an all-zero ID/EX bundle; no stall when Rs=Rt=0 or when the LW destination is r0.
- BEQ with Zero=1 at BRANCH_STAGE=2 -> PCSrc=1, IFIDFlush=1, and ID/EX plus EX/MEM zeroed; with Zero=0 nothing is flushed; BNE gives the opposite result.
- JAL in ID -> PCSrc=2, IFIDFlush=1 for one cycle; 3 cycles later WB_WriteReg=31, WB_RegWrite=1.
- JR in ID while the older BEQ is taken the same cycle -> PCSrc=1 (the branch wins) and the JR is squashed.
- hold=1 during a load-use stall -> all outputs stay frozen; the stall resolves normally after release.

Source files
------------

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - 5-stage pipeline control: decode, stage bundles, load-use stall, branch/jump redirect
module pipeline_control #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 3,
    parameter int BRANCH_STAGE   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [5:0]                OP,
    input  logic [5:0]                Funct,
    input  logic [REG_ADDR_WIDTH-1:0] Rs,
    input  logic [REG_ADDR_WIDTH-1:0] Rt,
    input  logic [REG_ADDR_WIDTH-1:0] Rd,
    input  logic                      Zero,
    input  logic                      hold,
    output logic                      PCWrite,
    output logic                      IFIDWrite,
    output logic                      IFIDFlush,
    output logic [1:0]                PCSrc,
    output logic                      EX_RegDst,
    output logic                      EX_ALUSrc,
    output logic [ALUOP_WIDTH-1:0]    EX_ALUOp,
    output logic                      MEM_MemRead,
    output logic                      MEM_MemWrite,
    output logic                      WB_RegWrite,
    output logic                      WB_MemtoReg,
    output logic [REG_ADDR_WIDTH-1:0] WB_WriteReg
);

    // Opcodes and the JR funct code
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    // ALUOp codes, zero-extended to the configured width
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_NONE = ALUOP_WIDTH'(0);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_LUI  = ALUOP_WIDTH'(1);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MEM  = ALUOP_WIDTH'(2);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_BR   = ALUOP_WIDTH'(3);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADDI = ALUOP_WIDTH'(4);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ORI  = ALUOP_WIDTH'(5);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ANDI = ALUOP_WIDTH'(6);
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_R    = ALUOP_WIDTH'(7);

    localparam logic [REG_ADDR_WIDTH-1:0] LINK_REG = {REG_ADDR_WIDTH{1'b1}};

    // PC select encodings
    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    // Full bundle held in ID/EX; branch flags ride along so they can resolve in EX or MEM
    typedef struct packed {
        logic                      reg_dst;
        logic                      alu_src;
        logic [ALUOP_WIDTH-1:0]    alu_op;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_write;
        logic                      mem_to_reg;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
        logic                      branch_eq;
        logic                      branch_ne;
    } ex_ctrl_t;

    // EX-only fields are dropped once the bundle leaves EX
    typedef struct packed {
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_write;
        logic                      mem_to_reg;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
        logic                      branch_eq;
        logic                      branch_ne;
    } mem_ctrl_t;

    typedef struct packed {
        logic                      reg_write;
        logic                      mem_to_reg;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
    } wb_ctrl_t;

    ex_ctrl_t  id_ctrl;
    logic      id_reads_rt;
    logic      id_jump;
    logic      id_jump_reg;

    ex_ctrl_t  idex_q,  idex_d;
    mem_ctrl_t exmem_q, exmem_d;
    wb_ctrl_t  memwb_q, memwb_d;

    logic      load_use;
    logic      br_eq;
    logic      br_ne;
    logic      branch_taken;

    // ID decode: opcode/funct to control bundle, destination register and jump kind
    always_comb begin
        id_ctrl     = '0;
        id_reads_rt = 1'b0;
        id_jump     = 1'b0;
        id_jump_reg = 1'b0;
        unique case (OP)
            OP_RTYPE: begin
                id_ctrl.reg_dst = 1'b1;
                id_ctrl.alu_op  = ALUOP_R;
                id_reads_rt     = 1'b1;
                if (Funct == FUNCT_JR) begin
                    id_jump_reg = 1'b1;
                end else begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.write_reg = Rd;
                end
            end
            OP_ADDI: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_ADDI;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.write_reg = Rt;
            end
            OP_ORI: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_ORI;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.write_reg = Rt;
            end
            OP_ANDI: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_ANDI;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.write_reg = Rt;
            end
            OP_LUI: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_LUI;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.write_reg = Rt;
            end
            OP_LW: begin
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.alu_op     = ALUOP_MEM;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.write_reg  = Rt;
            end
            OP_SW: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_MEM;
                id_ctrl.mem_write = 1'b1;
                id_reads_rt       = 1'b1;
            end
            OP_BEQ: begin
                id_ctrl.alu_op    = ALUOP_BR;
                id_ctrl.branch_eq = 1'b1;
                id_reads_rt       = 1'b1;
            end
            OP_BNE: begin
                id_ctrl.alu_op    = ALUOP_BR;
                id_ctrl.branch_ne = 1'b1;
                id_reads_rt       = 1'b1;
            end
            OP_J: begin
                id_ctrl.alu_op = ALUOP_NONE;
                id_jump        = 1'b1;
            end
            OP_JAL: begin
                id_ctrl.alu_op    = ALUOP_NONE;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.write_reg = LINK_REG;
                id_jump           = 1'b1;
            end
            default: begin
                id_ctrl = '0;
            end
        endcase
    end

    // Load-use: a load in EX whose non-zero destination is a source of the ID instruction
    always_comb begin
        load_use = idex_q.mem_read
                && (idex_q.write_reg != '0)
                && ((idex_q.write_reg == Rs)
                    || (id_reads_rt && (idex_q.write_reg == Rt)));
    end

    // Branch resolution on the bundle sitting in the resolving stage
    always_comb begin
        if (BRANCH_STAGE == 1) begin
            br_eq = idex_q.branch_eq;
            br_ne = idex_q.branch_ne;
        end else begin
            br_eq = exmem_q.branch_eq;
            br_ne = exmem_q.branch_ne;
        end
        branch_taken = (br_eq & Zero) | (br_ne & ~Zero);
    end

    // Fetch control: hold freezes everything, then branch > stall > jump
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        PCSrc     = PCSRC_SEQ;
        if (hold) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (branch_taken) begin
            PCSrc     = PCSRC_BRANCH;
            IFIDFlush = 1'b1;
        end else if (load_use) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (id_jump) begin
            PCSrc     = PCSRC_JUMP;
            IFIDFlush = 1'b1;
        end else if (id_jump_reg) begin
            PCSrc     = PCSRC_REG;
            IFIDFlush = 1'b1;
        end
    end

    // Next stage contents: advance unless held, inserting bubbles for flushes and stalls
    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        if (!hold) begin
            memwb_d.reg_write  = exmem_q.reg_write;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.write_reg  = exmem_q.write_reg;

            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
            exmem_d.write_reg  = idex_q.write_reg;
            exmem_d.branch_eq  = idex_q.branch_eq;
            exmem_d.branch_ne  = idex_q.branch_ne;

            idex_d = id_ctrl;

            if (branch_taken) begin
                idex_d = '0;
                if (BRANCH_STAGE == 2) begin
                    exmem_d = '0;
                end
            end else if (load_use) begin
                idex_d = '0;
            end
        end
    end

    // ID/EX stage register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // EX/MEM stage register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    // MEM/WB stage register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    // Stage outputs come straight from the stage registers
    assign EX_RegDst    = idex_q.reg_dst;
    assign EX_ALUSrc    = idex_q.alu_src;
    assign EX_ALUOp     = idex_q.alu_op;
    assign MEM_MemRead  = exmem_q.mem_read;
    assign MEM_MemWrite = exmem_q.mem_write;
    assign WB_RegWrite  = memwb_q.reg_write;
    assign WB_MemtoReg  = memwb_q.mem_to_reg;
    assign WB_WriteReg  = memwb_q.write_reg;

endmodule
